// File: rtl/sub_32bit_pipe.sv
// Two-stage valid/ready subtractor D = A - B with borrow out; low-half borrow registered.
// Define SUB32_OVF_EN to add a registered signed-overflow flag on OVF (else OVF is tied 0).
module sub_32bit_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             B_OUT,
    output logic             OVF
);
    localparam int unsigned HALF = WIDTH / 2;

    logic            s1_valid_q, s1_valid_d;
    logic            s1_bor_q, s1_bor_d;
    logic [HALF-1:0] s1_dlo_q, s1_dlo_d;
    logic [HALF-1:0] s1_ahi_q, s1_ahi_d;
    logic [HALF-1:0] s1_bhi_q, s1_bhi_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;

    logic          s2_ready, in_fire, s1_move, out_fire;
    logic [HALF:0] lo_diff, hi_diff;

    assign s2_ready = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;
    assign in_fire  = in_valid && in_ready;
    assign s1_move  = s1_valid_q && s2_ready;
    assign out_fire = s2_valid_q && out_ready;

    assign lo_diff = {1'b0, A[HALF-1:0]} - {1'b0, B[HALF-1:0]};
    assign hi_diff = {1'b0, s1_ahi_q} - {1'b0, s1_bhi_q} - {{HALF{1'b0}}, s1_bor_q};

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_bor_d   = s1_bor_q;
        s1_dlo_d   = s1_dlo_q;
        s1_ahi_d   = s1_ahi_q;
        s1_bhi_d   = s1_bhi_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_bor_d   = lo_diff[HALF];
            s1_dlo_d   = lo_diff[HALF-1:0];
            s1_ahi_d   = A[WIDTH-1:HALF];
            s1_bhi_d   = B[WIDTH-1:HALF];
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        d_d        = d_q;
        bout_d     = bout_q;
        if (s1_move) begin
            s2_valid_d = 1'b1;
            d_d        = {hi_diff[HALF-1:0], s1_dlo_q};
            bout_d     = hi_diff[HALF];
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_bor_q   <= 1'b0;
            s1_dlo_q   <= '0;
            s1_ahi_q   <= '0;
            s1_bhi_q   <= '0;
            s2_valid_q <= 1'b0;
            d_q        <= '0;
            bout_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_bor_q   <= s1_bor_d;
            s1_dlo_q   <= s1_dlo_d;
            s1_ahi_q   <= s1_ahi_d;
            s1_bhi_q   <= s1_bhi_d;
            s2_valid_q <= s2_valid_d;
            d_q        <= d_d;
            bout_q     <= bout_d;
        end
    end

`ifdef SUB32_OVF_EN
    // Operand sign bits already travel in the stage-1 high-half registers.
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (s1_move) begin
            ovf_d = (s1_ahi_q[HALF-1] != s1_bhi_q[HALF-1]) &&
                    (hi_diff[HALF-1] != s1_ahi_q[HALF-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`else
    assign OVF = 1'b0;
`endif

    assign out_valid = s2_valid_q;
    assign D         = d_q;
    assign B_OUT     = bout_q;

endmodule

// File: tb/tb_sub_32bit_pipe.sv
// Directed bench for sub_32bit_pipe: scoreboard of A-B results pushed on accept, popped on output.
module tb_sub_32bit_pipe;
    localparam int unsigned W = 32;
`ifdef SUB32_OVF_EN
    localparam logic OvfEn = 1'b1;
`else
    localparam logic OvfEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         in_ready, out_valid, b_out, ovf;
    logic [W-1:0] d_out;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [W+1:0] sb[$];
    int out_cyc[$];

    sub_32bit_pipe #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (a_in),
        .B        (b_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .D        (d_out),
        .B_OUT    (b_out),
        .OVF      (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W+1:0] obs, input logic [W+1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, borrow, difference}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] diff;
        logic       o;
        diff = {1'b0, a} - {1'b0, b};
        o = OvfEn && (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
        return {o, diff};
    endfunction

    // Scoreboard: pop on output transfer, then push on input transfer, both seen at negedge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (out_valid && out_ready) begin
                chk("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) chk("sb_result", {ovf, b_out, d_out}, sb.pop_front());
                out_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) sb.push_back(model(a_in, b_in));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc = 1'b0;
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accepted", acc, 1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
    endtask

    task automatic check_single(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] exp_d, input logic exp_b,
                                input logic exp_o);
        send(a, b);
        idle();
        chk("lat1_out_valid", out_valid, 0);
        step(1);
        chk("lat2_out_valid", out_valid, 1);
        chk("single_d", d_out, exp_d);
        chk("single_bout", b_out, exp_b);
        chk("single_ovf", ovf, exp_o);
        step(1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) step(1);
        chk("drained", sb.size(), 0);
    endtask

    logic [W-1:0] xa[4];
    logic [W-1:0] xb[4];

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_d", d_out, 0);
        chk("rst_bout", b_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Reset with two operands in flight.
        send(32'h1111_1111, 32'h0000_0001);
        send(32'h2222_2222, 32'h0000_0002);
        idle();
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_d", d_out, 0);
        chk("midrst_bout", b_out, 0);
        chk("midrst_in_ready", in_ready, 1);
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("no_stale_output", out_valid, 0);
        end
        check_single(32'h1234_5678, 32'h0234_5677, 32'h1000_0001, 1'b0, 1'b0);

        // Borrow and wrap boundaries.
        check_single(32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0);
        check_single(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check_single(32'h0000_1234, 32'h0000_5678, 32'hFFFF_BBBC, 1'b1, 1'b0);
        check_single(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0);
        check_single(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, OvfEn);

        // Back-to-back stream of 8 random pairs.
        out_cyc.delete();
        for (int i = 0; i < 8; i++) send($urandom, $urandom);
        idle();
        step(4);
        chk("stream_count", out_cyc.size(), 8);
        if (out_cyc.size() >= 8) chk("stream_consecutive", out_cyc[7] - out_cyc[0], 7);
        drain();

        // Backpressure: two results held, input stalls, then release.
        for (int i = 0; i < 4; i++) begin
            xa[i] = $urandom;
            xb[i] = $urandom;
        end
        out_cyc.delete();
        out_ready = 1'b0;
        send(xa[0], xb[0]);
        send(xa[1], xb[1]);
        in_valid = 1'b1;
        a_in = xa[2];
        b_in = xb[2];
        for (int i = 0; i < 4; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_hold", {ovf, b_out, d_out}, model(xa[0], xb[0]));
            step(1);
        end
        out_ready = 1'b1;
        send(xa[2], xb[2]);
        send(xa[3], xb[3]);
        idle();
        drain();
        step(2);
        chk("bp_delivered", out_cyc.size(), 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
